// File: rtl/spi_register_bank.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | spi_register_bank: SPI-slave register bank oversampled in the clk domain.  |
// | Optional SPI_REGBANK_BITOPS_EN enables set/clear/toggle ops. Rev 1.0       |
// +----------------------------------------------------------------------------+
module spi_register_bank #(
  parameter int          NREG         = 16,
  parameter int          W            = 24,
  parameter int          TEST_ADDR    = 7,
  parameter logic [23:0] UNMAPPED_VAL = 24'h0F0F0F
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            spi_clk,
  input  logic            spi_cs,
  input  logic            spi_mosi,
  output logic            spi_miso,
  output logic [NREG*W-1:0] regs,
  output logic            wr_strobe,
  output logic [4:0]      wr_addr,
  output logic            frame_err
);

  localparam logic [31:0]  c_alt       = 32'hAAAA_AAAA;
  localparam logic [W-1:0] c_test_rst  = c_alt[31 -: W];
  localparam logic [W-1:0] c_unmapped  = W'({8'd0, UNMAPPED_VAL});
  localparam logic [5:0]   c_done_cnt  = 6'(8 + W);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_CMD  = 3'd1,
    ST_DATA = 3'd2,
    ST_DONE = 3'd3,
    ST_OVER = 3'd4
  } state_t;

  logic r_sck_s1, r_sck_s2, r_sck_h;
  logic r_cs_s1, r_cs_s2, r_cs_h;
  logic r_mosi_s1, r_mosi_s2, r_mosi_h;
  logic r_sck_rise, r_sck_fall, r_cs_rise, r_cs_fall;

  state_t       r_state;
  logic [5:0]   r_cnt;
  logic [7:0]   r_cmd;
  logic [W-1:0] r_data;
  logic [W-1:0] r_out;
  logic         r_miso;
  logic         r_wr_strobe;
  logic         r_frame_err;
  logic [4:0]   r_wr_addr;
  logic [W-1:0] r_regs [NREG];

  logic [5:0]   w_cnt_inc;
  logic [7:0]   w_cmd_next;
  logic [W-1:0] w_rd_val;
  logic         w_addr_ok;
  logic         w_op_ok;
  logic [W-1:0] w_new;

  // Synchronisers are left unreset so that a pin level held through reset
  // never looks like a fresh edge once reset is released.
  always_ff @(posedge clk) begin
    r_sck_s1  <= spi_clk;
    r_sck_s2  <= r_sck_s1;
    r_sck_h   <= r_sck_s2;
    r_cs_s1   <= spi_cs;
    r_cs_s2   <= r_cs_s1;
    r_cs_h    <= r_cs_s2;
    r_mosi_s1 <= spi_mosi;
    r_mosi_s2 <= r_mosi_s1;
    r_mosi_h  <= r_mosi_s2;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sck_rise <= 1'b0;
      r_sck_fall <= 1'b0;
      r_cs_rise  <= 1'b0;
      r_cs_fall  <= 1'b0;
    end else begin
      r_sck_rise <= r_sck_s2 & ~r_sck_h;
      r_sck_fall <= ~r_sck_s2 & r_sck_h;
      r_cs_rise  <= r_cs_s2 & ~r_cs_h;
      r_cs_fall  <= ~r_cs_s2 & r_cs_h;
    end
  end

  function automatic state_t state_of(input logic [5:0] cnt);
    state_t s;
    if (cnt < 6'd8)             s = ST_CMD;
    else if (cnt < c_done_cnt)  s = ST_DATA;
    else if (cnt == c_done_cnt) s = ST_DONE;
    else                        s = ST_OVER;
    return s;
  endfunction

  assign w_cnt_inc  = (r_cnt == 6'd63) ? r_cnt : r_cnt + 6'd1;
  assign w_cmd_next = {r_cmd[6:0], r_mosi_h};
  assign w_addr_ok  = ({27'd0, r_cmd[4:0]} < 32'(NREG));

  // Read mux uses the command byte as it will look after the 8th bit lands.
  always_comb begin
    w_rd_val = c_unmapped;
    for (int i = 0; i < NREG; i++) begin
      if (w_cmd_next[4:0] == 5'(i)) w_rd_val = r_regs[i];
    end
  end

`ifdef SPI_REGBANK_BITOPS_EN
  logic [W-1:0] w_cur;

  always_comb begin
    w_cur = '0;
    for (int i = 0; i < NREG; i++) begin
      if (r_cmd[4:0] == 5'(i)) w_cur = r_regs[i];
    end
  end

  always_comb begin
    w_op_ok = 1'b1;
    case (r_cmd[6:5])
      2'b00:   w_new = r_data;
      2'b01:   w_new = w_cur | r_data;
      2'b10:   w_new = w_cur & ~r_data;
      default: w_new = w_cur ^ r_data;
    endcase
  end
`else
  always_comb begin
    w_op_ok = (r_cmd[6:5] == 2'b00);
    w_new   = r_data;
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_cmd       <= '0;
      r_data      <= '0;
      r_out       <= '0;
      r_miso      <= 1'b0;
      r_wr_strobe <= 1'b0;
      r_frame_err <= 1'b0;
      r_wr_addr   <= '0;
      for (int i = 0; i < NREG; i++) begin
        r_regs[i] <= (i == TEST_ADDR) ? c_test_rst : '0;
      end
    end else begin
      r_wr_strobe <= 1'b0;
      r_frame_err <= 1'b0;
      if (r_cs_rise) begin
        // cs rise outranks any SCK edge seen in the same cycle
        r_miso  <= 1'b0;
        r_state <= ST_IDLE;
        case (r_state)
          ST_DONE: begin
            if (!r_cmd[7]) begin
              if (!w_addr_ok || !w_op_ok) begin
                r_frame_err <= 1'b1;
              end else begin
                for (int i = 0; i < NREG; i++) begin
                  if (r_cmd[4:0] == 5'(i)) r_regs[i] <= w_new;
                end
                r_wr_strobe <= 1'b1;
                r_wr_addr   <= r_cmd[4:0];
              end
            end
          end
          ST_CMD, ST_DATA, ST_OVER: r_frame_err <= 1'b1;
          default: ;
        endcase
      end else if (r_state == ST_IDLE) begin
        if (r_cs_fall) begin
          r_state <= ST_CMD;
          r_cnt   <= '0;
          r_cmd   <= '0;
          r_data  <= '0;
          r_out   <= '0;
          r_miso  <= 1'b0;
        end
      end else if (r_sck_rise) begin
        r_cnt   <= w_cnt_inc;
        r_state <= state_of(w_cnt_inc);
        if (r_cnt < 6'd8)            r_cmd  <= w_cmd_next;
        else if (r_cnt < c_done_cnt) r_data <= {r_data[W-2:0], r_mosi_h};
        if (r_cnt == 6'd7)           r_out  <= w_rd_val;
      end else if (r_sck_fall) begin
        r_miso <= r_out[W-1];
        r_out  <= {r_out[W-2:0], 1'b0};
      end
    end
  end

  generate
    for (genvar g = 0; g < NREG; g++) begin : g_pack
      assign regs[g*W +: W] = r_regs[g];
    end
  endgenerate

  assign spi_miso  = r_miso;
  assign wr_strobe = r_wr_strobe;
  assign wr_addr   = r_wr_addr;
  assign frame_err = r_frame_err;

endmodule
`default_nettype wire

// File: tb/tb_spi_register_bank.sv
`default_nettype none
// Testbench for spi_register_bank: SPI master driver, reference model and
// expected-outcome queue checked after every frame.
module tb_spi_register_bank;

  localparam int NREG = 16;
  localparam int W    = 24;
  localparam int HALF = 8;
`ifdef SPI_REGBANK_BITOPS_EN
  localparam bit BITOPS = 1'b1;
`else
  localparam bit BITOPS = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              spi_clk = 1'b0;
  logic              spi_cs = 1'b1;
  logic              spi_mosi = 1'b0;
  logic              spi_miso;
  logic [NREG*W-1:0] regs;
  logic              wr_strobe;
  logic [4:0]        wr_addr;
  logic              frame_err;

  spi_register_bank #(.NREG(NREG), .W(W), .TEST_ADDR(7), .UNMAPPED_VAL(24'h0F0F0F)) dut (
    .clk(clk), .rst_n(rst_n), .spi_clk(spi_clk), .spi_cs(spi_cs), .spi_mosi(spi_mosi),
    .spi_miso(spi_miso), .regs(regs), .wr_strobe(wr_strobe), .wr_addr(wr_addr),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic         is_read;
    logic [W-1:0] rd;
    logic         strobe;
    logic         err;
    logic [4:0]   addr;
  } exp_t;

  exp_t         exp_q[$];
  logic [W-1:0] mreg [NREG];
  int           total = 0;
  int           bad = 0;
  int           strobe_cnt = 0;
  int           err_cnt = 0;
  int           both_cnt = 0;

  always @(negedge clk) begin
    if (wr_strobe) strobe_cnt <= strobe_cnt + 1;
    if (frame_err) err_cnt <= err_cnt + 1;
    if (wr_strobe && frame_err) both_cnt <= both_cnt + 1;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < NREG; i++) mreg[i] = '0;
    mreg[7] = 24'hAAAAAA;
  endtask

  function automatic logic [NREG*W-1:0] mpack();
    logic [NREG*W-1:0] v;
    for (int i = 0; i < NREG; i++) v[i*W +: W] = mreg[i];
    return v;
  endfunction

  task automatic model(input int nbits, input logic [7:0] cmd, input logic [W-1:0] d,
                       output exp_t e);
    logic [4:0] a;
    logic [1:0] op;
    a = cmd[4:0];
    op = cmd[6:5];
    e = '0;
    e.addr = a;
    e.is_read = cmd[7] && (nbits == 8 + W);
    if (e.is_read) e.rd = (a < NREG) ? mreg[a[3:0]] : 24'h0F0F0F;
    if (nbits != 8 + W) e.err = 1'b1;
    else if (!cmd[7]) begin
      if (a >= NREG) e.err = 1'b1;
      else if (op != 2'b00 && !BITOPS) e.err = 1'b1;
      else begin
        case (op)
          2'b00:   mreg[a[3:0]] = d;
          2'b01:   mreg[a[3:0]] = mreg[a[3:0]] | d;
          2'b10:   mreg[a[3:0]] = mreg[a[3:0]] & ~d;
          default: mreg[a[3:0]] = mreg[a[3:0]] ^ d;
        endcase
        e.strobe = 1'b1;
      end
    end
  endtask

  // MISO is sampled just before each SCK rise, as a mode-0 master would.
  task automatic shift_bits(input int nbits, input logic [63:0] tx, output logic [63:0] rx);
    rx = '0;
    for (int i = nbits - 1; i >= 0; i--) begin
      spi_mosi = tx[i];
      tick(HALF);
      rx = {rx[62:0], spi_miso};
      spi_clk = 1'b1;
      tick(HALF);
      spi_clk = 1'b0;
    end
    tick(HALF);
  endtask

  task automatic run_frame(input int nbits, input logic [7:0] cmd, input logic [W-1:0] d);
    exp_t        e;
    logic [63:0] f, tx, rx;
    int          s0, e0;
    model(nbits, cmd, d, e);
    exp_q.push_back(e);
    f = {32'd0, cmd, d};
    tx = (nbits <= 32) ? (f >> (32 - nbits)) : (f << (nbits - 32));
    s0 = strobe_cnt;
    e0 = err_cnt;
    spi_cs = 1'b0;
    tick(HALF);
    shift_bits(nbits, tx, rx);
    spi_cs = 1'b1;
    tick(12);
    e = exp_q.pop_front();
    if (e.is_read) begin
      total++;
      if (rx[W-1:0] !== e.rd) begin bad++; $display("FAIL read cmd=%h: got %h want %h", cmd, rx[W-1:0], e.rd); end
    end
    total++;
    if (strobe_cnt - s0 !== int'(e.strobe)) begin bad++; $display("FAIL strobe cmd=%h: got %0d want %0d", cmd, strobe_cnt - s0, e.strobe); end
    total++;
    if (err_cnt - e0 !== int'(e.err)) begin bad++; $display("FAIL frame_err cmd=%h bits=%0d: got %0d want %0d", cmd, nbits, err_cnt - e0, e.err); end
    if (e.strobe) begin
      total++;
      if (wr_addr !== e.addr) begin bad++; $display("FAIL wr_addr: got %0d want %0d", wr_addr, e.addr); end
    end
    total++;
    if (regs !== mpack()) begin bad++; $display("FAIL regs after cmd=%h: got %h want %h", cmd, regs, mpack()); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(6);
    rst_n = 1'b1;
    model_reset();
    tick(4);
    total++;
    if (regs[7*W +: W] !== 24'hAAAAAA) begin bad++; $display("FAIL reset reg7: got %h want aaaaaa", regs[7*W +: W]); end
    total++;
    if (regs !== mpack()) begin bad++; $display("FAIL reset regs: got %h want %h", regs, mpack()); end
    total++;
    if ({spi_miso, wr_strobe, frame_err, wr_addr} !== 8'h00) begin
      bad++; $display("FAIL reset outputs: got miso=%b strobe=%b err=%b addr=%0d want all 0", spi_miso, wr_strobe, frame_err, wr_addr);
    end
  endtask

  task automatic test_write_read();
    run_frame(32, 8'h87, 24'h0);
    run_frame(32, 8'h08, 24'h123456);
    run_frame(32, 8'h88, 24'h0);
    run_frame(32, 8'h08, 24'h123456);
  endtask

  task automatic test_bitops();
    run_frame(32, 8'h03, 24'h00F0F0);
    run_frame(32, 8'h23, 24'h000F00);
    run_frame(32, 8'h43, 24'h0000F0);
    run_frame(32, 8'h63, 24'hFFFFFF);
    run_frame(32, 8'h83, 24'h0);
  endtask

  task automatic test_bad_frames();
    run_frame(31, 8'h08, 24'hDEADBE);
    run_frame(33, 8'h08, 24'hDEADBE);
    run_frame(5, 8'h08, 24'h0);
    run_frame(32, 8'h94, 24'h0);
    run_frame(32, 8'h14, 24'h111111);
  endtask

  task automatic test_mid_reset();
    logic [63:0] rx;
    int          s0, e0;
    s0 = strobe_cnt;
    e0 = err_cnt;
    spi_cs = 1'b0;
    tick(HALF);
    shift_bits(12, 64'h0000_0000_0000_0025, rx);
    rst_n = 1'b0;
    tick(4);
    rst_n = 1'b1;
    model_reset();
    shift_bits(20, 64'h0000_0000_000A_BCDE, rx);
    spi_cs = 1'b1;
    tick(12);
    total++;
    if (strobe_cnt - s0 !== 0) begin bad++; $display("FAIL midreset strobe: got %0d want 0", strobe_cnt - s0); end
    total++;
    if (err_cnt - e0 !== 0) begin bad++; $display("FAIL midreset frame_err: got %0d want 0", err_cnt - e0); end
    total++;
    if (regs !== mpack()) begin bad++; $display("FAIL midreset regs: got %h want %h", regs, mpack()); end
    run_frame(32, 8'h02, 24'h5A5A5A);
  endtask

  task automatic test_back_to_back();
    logic [7:0]   cmd;
    logic [W-1:0] d;
    for (int n = 0; n < 6; n++) begin
      cmd = {1'b0, 2'($urandom_range(0, 3)), 5'($urandom_range(0, NREG - 1))};
      d = W'($urandom);
      run_frame(32, cmd, d);
      cmd = {3'b100, 5'($urandom_range(0, NREG - 1))};
      run_frame(32, cmd, 24'h0);
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_bitops();
    test_bad_frames();
    test_mid_reset();
    test_back_to_back();
    total++;
    if (both_cnt !== 0) begin bad++; $display("FAIL strobe_and_err_overlap: got %0d want 0", both_cnt); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/spi_register_bank.md
# spi_register_bank

Parametrised SPI-slave register bank: the successor to the fixed four-register SPI register set. All SPI pins are oversampled in the single system clock domain, so there is no SPI-clocked logic. It adds a configurable register count and width, per-register reset values, bitwise set/clear/toggle write operations, a write strobe and frame-error reporting. It sits between the MCU SPI port and the control registers (LED, SPI mux, 4094, mode) of the DMM fabric.

## Interface
- NREG, 16: number of registers; addresses 0..NREG-1; NREG ≤ 32.
- W, 24: register width in bits; 8 ≤ W ≤ 32.
- TEST_ADDR, 7: address of the test register; resets to alternating 1010… (MSB = 1).
- UNMAPPED_VAL, 24'h0F0F0F: read value for addresses ≥ NREG, truncated or zero-extended to W.
- clk  in  1  system clock.
- rst_n  in  1  synchronous active-low reset.
- spi_clk  in  1  SPI SCK, asynchronous.
- spi_cs  in  1  SPI chip select, active low, asynchronous.
- spi_mosi  in  1  SPI data in.
- spi_miso  out  1  SPI data out; 0 while deselected.
- regs  out  NREG*W  packed register contents; register i occupies bits [i*W +: W].
- wr_strobe  out  1  one-clk pulse when a register is modified.
- wr_addr  out  5  address of the last modification; valid with wr_strobe and held afterwards.
- frame_err  out  1  one-clk pulse when a frame is discarded.

## Operation
- **Input synchronisers.** spi_clk, spi_cs and spi_mosi each pass through 2 flops, then 1 history flop for edge detection. The SPI mode is 0: MOSI is sampled on a detected SCK rise, and MISO is updated on a detected SCK fall.
- **Frame format.** MSB first. Command byte = {rnw, op[1:0], addr[4:0]}, followed by W data bits.
  - rnw = 1: read.
  - op: 00 write, 01 set, 10 clear, 11 toggle.
- **States.**
  - IDLE: cs high.
  - CMD: bit count 0..7.
  - DATA: bit count 8..8+W-1.
  - DONE: count = 8+W.
  - OVER: count > 8+W; the counter saturates at 63.
  - cs falling moves IDLE to CMD and clears the counter and shift registers.
- **Read path.** On the 8th detected SCK rise, the out-shift register is loaded with the addressed register, or UNMAPPED_VAL for addresses ≥ NREG. Its MSB is driven on the next detected SCK fall. Each subsequent fall shifts it left with zero fill.
- **Commit.** Evaluated on detected cs rise, then the block returns to IDLE.
  - Only DONE with rnw = 0 and addr < NREG modifies a register:
    - write: reg = d.
    - set: reg = reg | d.
    - clear: reg = reg & ~d.
    - toggle: reg = reg ^ d.
  - Committing the same value still pulses wr_strobe.
  - A read frame in DONE: no change, no pulse.
- **frame_err pulses** on any of:
  - cs rise in CMD, DATA or OVER.
  - A write to addr ≥ NREG.
  - A disabled op (see Configuration).
- **Reset.** regs = 0 except TEST_ADDR = 1010…. spi_miso = 0, wr_strobe = 0, frame_err = 0, wr_addr = 0, state IDLE. After reset the block ignores SCK until a fresh cs falling edge, so a frame in progress during reset is discarded silently.
- **Simultaneous events.** If cs rise and an SCK edge are detected in the same cycle, cs wins and the SCK edge is ignored.

## Timing
- clk must be ≥ 8× SCK frequency; SCK high and low times must each be ≥ 4 clk periods.
- Let E0 be the clk edge at which the first synchroniser flop captures a pin change. The edge is detected at E2, and the resulting action registers at E3.
- regs, wr_strobe and frame_err change at E3 after cs rises.
- spi_miso updates at E3 after a SCK fall. It is 0 from E3 after cs rises until the 8th SCK fall of the next frame.
- wr_strobe and frame_err are exactly 1 clk wide and never assert in the same cycle.

## Configuration
- SPI_REGBANK_BITOPS_EN defined: op codes 01, 10 and 11 behave as specified in Operation.
- SPI_REGBANK_BITOPS_EN undefined: only op = 00 writes. Any write frame with op ≠ 00 is discarded with a frame_err pulse. Read frames ignore op.

## Test plan
- Reset with W = 24 → regs[7] = 0xAAAAAA, all other registers 0; a read of addr 7 returns 0xAAAAAA on MISO.
- Write 0x123456 to addr 8 (command 0x08) → regs[8] = 0x123456, one wr_strobe with wr_addr = 8; a read (command 0x88) returns 0x123456.
- With BITOPS enabled, starting from 0x00F0F0:
  - set 0x000F00 → 0x00FFF0;
  - clear 0x0000F0 → 0x00FF00;
  - toggle 0xFFFFFF → 0xFF00FF.
- Write frame with 31 or 33 bits, then cs rise → register unchanged, one frame_err pulse, no wr_strobe.
- Read of addr 20 with NREG = 16 → MISO returns 0x0F0F0F; write to addr 20 → frame_err pulse.
- rst_n asserted mid-frame, then released while cs is still low and SCK continues → no commit until cs goes high and a new frame completes.
